weight_sram_stream: RTL and testbench

//   Parametrised weight store for the systolic array: LANES x LANE_W-bit words, DEPTH entries.

---
 rtl/weight_sram_stream_pkg.sv | 25 ++
 rtl/weight_sram_stream_if.sv | 15 +
 rtl/weight_sram_stream_skid_fifo2.sv | 61 ++++++
 rtl/weight_sram_stream.sv | 165 ++++++++++++++++
 tb/tb_weight_sram_stream.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/weight_sram_stream_pkg.sv
// Shared constants, burst FSM state type and address helpers for the weight store.
// Every file of the block takes its geometry from here.
package weight_sram_stream_pkg;

    localparam int LANE_W         = 4;
    localparam int LANES          = 25;
    localparam int W              = LANES * LANE_W;
    localparam int DEPTH          = 20000;
    localparam int ADDR_W         = 15;
    localparam int CYCLE_PERIOD_NS = 10;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } burst_state_e;

    // Burst addresses wrap from the last word back to word 0.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/weight_sram_stream_if.sv
// Valid/ready stream carrying weight words from the burst engine to the PE array.
// master = producer (weight store), slave = consumer.
interface weight_sram_stream_if
    import weight_sram_stream_pkg::*;
#(
    parameter int DW = W
);
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          s_last;

    modport master (output s_valid, output s_data, output s_last, input s_ready);
    modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/weight_sram_stream_skid_fifo2.sv
// Two-entry skid FIFO (head/tail registers) with valid/ready on both sides.
// The occupancy count is exported so the producer can throttle its issue.
module weight_sram_stream_skid_fifo2 #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [1:0]    count
);

    logic [DW-1:0] head_q, head_d;
    logic [DW-1:0] tail_q, tail_d;
    logic [1:0]    count_q, count_d;
    logic          push, pop;
    logic [1:0]    fill_after_pop;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_data  = head_q;
    assign count     = count_q;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_comb begin
        head_d         = head_q;
        tail_d         = tail_q;
        fill_after_pop = count_q - {1'b0, pop};
        count_d        = fill_after_pop + {1'b0, push};
        if (pop && count_q == 2'd2) begin
            head_d = tail_q;
        end
        // New entry lands in whichever slot is free once the pop is accounted for.
        if (push) begin
            if (fill_after_pop == 2'd0) begin
                head_d = in_data;
            end else begin
                tail_d = in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/weight_sram_stream.sv
// Weight store for the systolic array: lane-masked writes, single-word random reads,
// and a burst engine streaming a contiguous (wrapping) range through a 2-entry skid FIFO.
module weight_sram_stream
    import weight_sram_stream_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  csb,
    input  logic                  wsb,
    input  logic [LANES-1:0]      wmask,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [W-1:0]          wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [W-1:0]          rdata,
    output logic                  rvalid,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base,
    input  logic [ADDR_W:0]       len,
    output logic                  busy,
    output logic                  done,
    output logic                  oob_err,
    weight_sram_stream_if.master  strm
);

    localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W + 1)'(1);

    burst_state_e      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   remaining_q, remaining_d;
    logic [W-1:0]      rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              done_q, done_d;
    logic              oob_err_q, oob_err_d;

    logic              wr_req, wr_oob, wr_en;
    logic              rd_req, rd_oob;
    logic              start_oob;
    logic              issue;
    logic [W-1:0]      rd_rand_word, rd_burst_word;

    logic              fifo_in_ready;
    logic              fifo_out_valid;
    logic [W:0]        fifo_out_data;
    logic [1:0]        fifo_count;
    logic              fifo_pop;

    assign wr_req = ~csb & ~wsb;
    assign wr_oob = (waddr > LAST_ADDR);
    assign wr_en  = wr_req & ~wr_oob;
    assign rd_req = ~csb & wsb & (state_q == ST_IDLE);
    assign rd_oob = (raddr > LAST_ADDR);

    // One narrow array per lane gives true per-lane write enables.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [LANE_W-1:0] mem [0:DEPTH-1];

        always_ff @(posedge clk) begin
            if (wr_en && wmask[g]) begin
                mem[waddr] <= wdata[g*LANE_W +: LANE_W];
            end
        end

        assign rd_rand_word[g*LANE_W +: LANE_W]  = mem[raddr];
        assign rd_burst_word[g*LANE_W +: LANE_W] = mem[addr_q];
    end

    // Issued reads land in the FIFO at the issue edge, so the only read in flight
    // is the one being issued; occupancy alone decides whether another may go.
    weight_sram_stream_skid_fifo2 #(
        .DW (W + 1)
    ) u_skid_fifo2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (issue),
        .in_ready  (fifo_in_ready),
        .in_data   ({(remaining_q == LEN_ONE), rd_burst_word}),
        .out_valid (fifo_out_valid),
        .out_ready (strm.s_ready),
        .out_data  (fifo_out_data),
        .count     (fifo_count)
    );

    assign fifo_pop = fifo_out_valid & strm.s_ready;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        start_oob   = 1'b0;
        issue       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (base > LAST_ADDR) begin
                        start_oob = 1'b1;
                    end else if (len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d     = ST_ISSUE;
                        addr_d      = base;
                        remaining_d = len;
                    end
                end
            end
            ST_ISSUE: begin
                if (fifo_in_ready) begin
                    issue       = 1'b1;
                    addr_d      = next_addr(addr_q);
                    remaining_d = remaining_q - LEN_ONE;
                    if (remaining_q == LEN_ONE) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Leave as the final beat pops so done lands the cycle after it.
                if (!fifo_out_valid || (fifo_pop && fifo_count == 2'd1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rvalid_d  = rd_req;
        rdata_d   = rdata_q;
        oob_err_d = (wr_req & wr_oob) | (rd_req & rd_oob) | start_oob;
        if (rd_req) begin
            rdata_d = rd_oob ? '0 : rd_rand_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            done_q      <= 1'b0;
            oob_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
            done_q      <= done_d;
            oob_err_q   <= oob_err_d;
        end
    end

    assign rdata        = rdata_q;
    assign rvalid       = rvalid_q;
    assign done         = done_q;
    assign oob_err      = oob_err_q;
    assign busy         = (state_q != ST_IDLE);
    assign strm.s_valid = fifo_out_valid;
    assign strm.s_data  = fifo_out_data[W-1:0];
    assign strm.s_last  = fifo_out_valid & fifo_out_data[W];

endmodule

// File: tb/tb_weight_sram_stream.sv
// Self-checking bench for weight_sram_stream: random words and masks against an array
// model, bursts checked against an expected-beat queue built with modulo addressing.
module tb_weight_sram_stream;
    import weight_sram_stream_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              csb, wsb;
    logic [LANES-1:0]  wmask;
    logic [ADDR_W-1:0] waddr, raddr, base;
    logic [W-1:0]      wdata, rdata;
    logic              rvalid, start, busy, done, oob_err;
    logic [ADDR_W:0]   len;

    weight_sram_stream_if strm ();

    weight_sram_stream dut (
        .clk (clk), .rst (rst), .csb (csb), .wsb (wsb), .wmask (wmask),
        .waddr (waddr), .wdata (wdata), .raddr (raddr), .rdata (rdata),
        .rvalid (rvalid), .start (start), .base (base), .len (len),
        .busy (busy), .done (done), .oob_err (oob_err), .strm (strm)
    );

    always #(CYCLE_PERIOD_NS / 2) clk = ~clk;

    logic [W-1:0] mdl [DEPTH];
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rand_word();
        return W'({$urandom(), $urandom(), $urandom(), $urandom()});
    endfunction

    function automatic int rand_addr();
        if ($urandom_range(0, 1) == 0) return $urandom_range(0, 39);
        return $urandom_range(DEPTH - 40, DEPTH - 1);
    endfunction

    function automatic void mdl_write(input int a, input logic [LANES-1:0] m, input logic [W-1:0] d);
        for (int i = 0; i < LANES; i++)
            if (m[i]) mdl[a][i*LANE_W +: LANE_W] = d[i*LANE_W +: LANE_W];
    endfunction

    task automatic wr(input int a, input logic [LANES-1:0] m, input logic [W-1:0] d);
        csb = 1'b0; wsb = 1'b0; waddr = ADDR_W'(a); wmask = m; wdata = d;
        tick();
        csb = 1'b1; wsb = 1'b1;
        if (a < DEPTH) mdl_write(a, m, d);
    endtask

    task automatic rd(input int a, input string tag);
        logic [W-1:0] e;
        e = '0;
        if (a < DEPTH) e = mdl[a];
        csb = 1'b0; wsb = 1'b1; raddr = ADDR_W'(a);
        tick();
        csb = 1'b1;
        chk({tag, "_rvalid"}, rvalid, 1'b1);
        chk({tag, "_rdata"}, rdata, e);
        chk({tag, "_oob"}, oob_err, (a >= DEPTH));
        tick();
        chk({tag, "_rvalid_drop"}, rvalid, 1'b0);
        chk({tag, "_rdata_hold"}, rdata, e);
    endtask

    // mode 0: ready held high, 1: ready pattern 1,0,0 repeating, 2: random ready.
    task automatic run_burst(input int b, input int n, input int mode, input bit mid_wr);
        logic [W-1:0] exp_q [$];
        logic [W-1:0] held, nd;
        int  beats, cyc, first_cyc, last_cyc;
        bit  holding, done_seen, rdy;
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(mdl[(b + i) % DEPTH]);
        start = 1'b1; base = ADDR_W'(b); len = (ADDR_W + 1)'(n);
        tick();
        start = 1'b0;
        beats = 0; cyc = 1; first_cyc = -1; last_cyc = -1;
        holding = 1'b0; done_seen = 1'b0; held = '0;
        while (!done_seen && cyc < 300) begin
            if (cyc == 4 && n >= 4) begin
                chk("rd_ignored_busy", rvalid, 1'b0);
                chk("rd_busy_no_oob", oob_err, 1'b0);
            end
            csb = 1'b1; wsb = 1'b1;
            if (mid_wr && cyc == 1) begin
                nd = rand_word();
                csb = 1'b0; wsb = 1'b0; waddr = ADDR_W'(b); wmask = '1; wdata = nd;
                mdl_write(b, '1, nd);
            end else if (mid_wr && cyc == 2) begin
                nd = rand_word();
                csb = 1'b0; wsb = 1'b0; waddr = ADDR_W'((b + n - 1) % DEPTH); wmask = '1; wdata = nd;
                mdl_write((b + n - 1) % DEPTH, '1, nd);
                exp_q[n-1] = nd;
            end else if (cyc == 3 && n >= 4) begin
                csb = 1'b0; wsb = 1'b1; raddr = ADDR_W'(b);
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ((cyc - 1) % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            strm.s_ready = rdy;
            if (done) begin
                done_seen = 1'b1;
                chk("done_after_all_beats", beats, n);
                chk("done_one_after_last", cyc, last_cyc + 1);
                chk("busy_low_at_done", busy, 1'b0);
            end
            if (holding) begin
                chk("stall_valid_held", strm.s_valid, 1'b1);
                chk("stall_data_held", strm.s_data, held);
                holding = 1'b0;
            end
            if (strm.s_valid && !done_seen) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (rdy) begin
                    if (beats < n) begin
                        chk("beat_data", strm.s_data, exp_q[beats]);
                        chk("beat_last", strm.s_last, (beats == n - 1));
                    end else begin
                        chk("extra_beat", beats, n - 1);
                    end
                    beats++;
                    last_cyc = cyc;
                end else begin
                    held = strm.s_data;
                    holding = 1'b1;
                end
            end
            tick();
            cyc++;
        end
        csb = 1'b1; wsb = 1'b1;
        if (!done_seen) chk("done_timeout", 1'b0, 1'b1);
        chk("beat_count", beats, n);
        if (mode == 0) begin
            chk("first_beat_cycle", first_cyc, 2);
            chk("zero_bubble_last", last_cyc, n + 1);
        end
        chk("done_single_pulse", done, 1'b0);
        chk("no_valid_after_done", strm.s_valid, 1'b0);
        strm.s_ready = 1'b1;
    endtask

    initial begin
        int beats;
        rst = 1'b1; csb = 1'b1; wsb = 1'b1; wmask = '0; waddr = '0; wdata = '0;
        raddr = '0; start = 1'b0; base = '0; len = '0; strm.s_ready = 1'b1;
        repeat (3) tick();
        chk("rst_rdata", rdata, '0);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_s_valid", strm.s_valid, 1'b0);
        chk("rst_s_data", strm.s_data, '0);
        chk("rst_s_last", strm.s_last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_oob", oob_err, 1'b0);
        rst = 1'b0;
        tick();

        for (int a = 0; a < 40; a++) wr(a, '1, rand_word());
        for (int a = DEPTH - 40; a < DEPTH; a++) wr(a, '1, rand_word());

        wr(5, '1, {LANES{4'hA}});
        rd(5, "full_write");
        chk("full_write_value", rdata, {LANES{4'hA}});
        wr(5, LANES'(1), {{(LANES-1){4'h0}}, 4'h3});
        rd(5, "masked_write");
        chk("masked_write_value", rdata, {{(LANES-1){4'hA}}, 4'h3});

        run_burst(DEPTH - 2, 4, 0, 1'b0);
        run_burst(10, 8, 1, 1'b1);

        start = 1'b1; base = 3; len = '0;
        tick();
        start = 1'b0;
        chk("len0_done", done, 1'b1);
        chk("len0_busy", busy, 1'b0);
        chk("len0_no_valid", strm.s_valid, 1'b0);
        tick();
        chk("len0_done_pulse", done, 1'b0);
        chk("len0_no_valid2", strm.s_valid, 1'b0);

        rd(DEPTH, "oob_read");

        wr(DEPTH + 1, '1, rand_word());
        chk("oob_write_err", oob_err, 1'b1);
        tick();
        chk("oob_err_pulse", oob_err, 1'b0);

        start = 1'b1; base = ADDR_W'(DEPTH); len = 3;
        tick();
        start = 1'b0;
        chk("oob_base_err", oob_err, 1'b1);
        chk("oob_base_busy", busy, 1'b0);
        chk("oob_base_done", done, 1'b0);
        tick();
        chk("oob_base_no_done", done, 1'b0);
        chk("oob_base_idle", busy, 1'b0);

        start = 1'b1; base = 0; len = 10;
        tick();
        start = 1'b0;
        beats = 0;
        for (int c = 0; c < 20 && beats < 3; c++) begin
            if (strm.s_valid && strm.s_ready) beats++;
            if (beats == 3) rst = 1'b1;
            tick();
        end
        chk("rst_mid_reached_beat3", beats, 3);
        chk("rst_mid_s_valid", strm.s_valid, 1'b0);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_done", done, 1'b0);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("rst_mid_no_done", done, 1'b0);
        end
        run_burst(2, 5, 0, 1'b0);

        for (int k = 0; k < 24; k++) begin
            if ($urandom_range(0, 1) == 0) wr(rand_addr(), LANES'($urandom()), rand_word());
            else rd(rand_addr(), "rand_read");
        end
        for (int k = 0; k < 6; k++) begin
            if ($urandom_range(0, 1) == 0) run_burst($urandom_range(0, 20), $urandom_range(1, 16), 2, 1'b0);
            else run_burst($urandom_range(DEPTH - 20, DEPTH - 1), $urandom_range(1, 16), 2, 1'b0);
        end
        run_burst($urandom_range(DEPTH - 8, DEPTH - 1), $urandom_range(2, 16), 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
